exe_stage: RTL and testbench

- Execute stage of the 5-stage in-order LoongArch pipeline; sits between decode and memory.
- Accepts decoded operands from decode and computes single-cycle ALU results (existing alu block, alu_op[14:0]).
- Runs div.w/div.wu/mod.w/mod.wu in an iterative multi-cycle divider, stalling the stage until the result is ready.
- Issues data-SRAM requests and publishes a bypass/block bus back to decode.

---
 rtl/exe_stage.sv | 190 +++++++++++++++++++
 tb/tb_exe_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// exe_stage: LoongArch EXE stage with a single-cycle ALU, an iterative restoring divider and the data-SRAM request.
// Define EXE_DIV_RADIX4_EN to retire two quotient bits per divider cycle (16 steps instead of 32).
module exe_stage #(
  parameter int unsigned DIV_BITS = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         id_exe_valid,
  output logic         exe_allowin,
  input  logic [186:0] id_exe_bus,
  input  logic         mem_allowin,
  output logic         exe_mem_valid,
  output logic [102:0] exe_mem_bus,
  output logic [38:0]  exe_wr_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata
);

`ifdef EXE_DIV_RADIX4_EN
  localparam int unsigned DIV_STEPS = DIV_BITS / 2;
`else
  localparam int unsigned DIV_STEPS = DIV_BITS;
`endif
  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;

  logic                  exe_valid_q, exe_valid_d;
  logic [186:0]          bus_q, bus_d;
  div_state_e            state_q, state_d;
  logic [DIV_BITS-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [2*DIV_BITS-1:0] step;

  logic        gr_we, mem_we, res_from_mem;
  logic [18:0] alu_op;
  logic [31:0] src1, src2, rkd_value, inst, pc;
  logic [4:0]  dest;

  assign {gr_we, mem_we, res_from_mem, alu_op, src1, src2, dest, rkd_value, inst, pc} = bus_q;

  logic        is_div, div_signed, exe_ready_go;
  logic [31:0] alu_res, div_res, result, src1_mag, src2_mag;
  logic [31:0] quo_fix, rem_fix;
  logic [63:0] prod_u;
  logic [31:0] mulh_s;

  // ---------------- single-cycle ALU ----------------
  assign prod_u = {32'd0, src1} * {32'd0, src2};
  // Signed high product derived from the unsigned one so a single multiplier serves both.
  assign mulh_s = prod_u[63:32] - (src1[31] ? src2 : 32'd0) - (src2[31] ? src1 : 32'd0);

  always_comb begin
    alu_res = '0;
    if (alu_op[0])  alu_res = alu_res | (src1 + src2);
    if (alu_op[1])  alu_res = alu_res | (src1 - src2);
    if (alu_op[2])  alu_res = alu_res | {31'd0, $signed(src1) < $signed(src2)};
    if (alu_op[3])  alu_res = alu_res | {31'd0, src1 < src2};
    if (alu_op[4])  alu_res = alu_res | (src1 & src2);
    if (alu_op[5])  alu_res = alu_res | ~(src1 | src2);
    if (alu_op[6])  alu_res = alu_res | (src1 | src2);
    if (alu_op[7])  alu_res = alu_res | (src1 ^ src2);
    if (alu_op[8])  alu_res = alu_res | (src1 << src2[4:0]);
    if (alu_op[9])  alu_res = alu_res | (src1 >> src2[4:0]);
    if (alu_op[10]) alu_res = alu_res | 32'($signed(src1) >>> src2[4:0]);
    if (alu_op[11]) alu_res = alu_res | src2;
    if (alu_op[12]) alu_res = alu_res | prod_u[31:0];
    if (alu_op[13]) alu_res = alu_res | mulh_s;
    if (alu_op[14]) alu_res = alu_res | prod_u[63:32];
  end

  // ---------------- iterative divider ----------------
  assign is_div     = |alu_op[18:15];
  assign div_signed = alu_op[15] | alu_op[16];
  assign src1_mag   = (div_signed && src1[31]) ? (~src1 + 32'd1) : src1;
  assign src2_mag   = (div_signed && src2[31]) ? (~src2 + 32'd1) : src2;

  function automatic logic [2*DIV_BITS-1:0] div_step(
    input logic [DIV_BITS-1:0] rem,
    input logic [DIV_BITS-1:0] quo,
    input logic [DIV_BITS-1:0] dvs
  );
    logic [DIV_BITS:0] sh;
    sh = {rem, quo[DIV_BITS-1]};
    if (sh >= {1'b0, dvs}) div_step = {sh[DIV_BITS-1:0] - dvs, quo[DIV_BITS-2:0], 1'b1};
    else                   div_step = {sh[DIV_BITS-1:0], quo[DIV_BITS-2:0], 1'b0};
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    step    = '0;
    case (state_q)
      DIV_IDLE: begin
        if (exe_valid_q && is_div) begin
          state_d = DIV_CALC;
          rem_d   = '0;
          quo_d   = src1_mag;
          dvs_d   = src2_mag;
          cnt_d   = '0;
        end
      end
      DIV_CALC: begin
        step = div_step(rem_q, quo_q, dvs_q);
`ifdef EXE_DIV_RADIX4_EN
        step = div_step(step[2*DIV_BITS-1:DIV_BITS], step[DIV_BITS-1:0], dvs_q);
`endif
        rem_d = step[2*DIV_BITS-1:DIV_BITS];
        quo_d = step[DIV_BITS-1:0];
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == DIV_LAST) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (mem_allowin) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Sign fix-up uses the latched operands, which stay frozen while the stage is stalled.
  always_comb begin
    quo_fix = (div_signed && (src1[31] ^ src2[31])) ? (~quo_q + 32'd1) : quo_q;
    rem_fix = (div_signed && src1[31]) ? (~rem_q + 32'd1) : rem_q;
    if (src2 == 32'd0) begin
      quo_fix = '1;
      rem_fix = src1;
    end
    div_res = (alu_op[15] | alu_op[17]) ? quo_fix : rem_fix;
  end

  // ---------------- pipeline handshake ----------------
  assign exe_ready_go  = ~is_div | (state_q == DIV_DONE);
  assign exe_allowin   = ~exe_valid_q | (exe_ready_go & mem_allowin);
  assign exe_mem_valid = exe_valid_q & exe_ready_go;

  always_comb begin
    exe_valid_d = exe_valid_q;
    bus_d       = bus_q;
    if (exe_allowin) exe_valid_d = id_exe_valid;
    if (id_exe_valid && exe_allowin) bus_d = id_exe_bus;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exe_valid_q <= 1'b0;
      bus_q       <= '0;
      state_q     <= DIV_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      bus_q       <= bus_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------- outputs ----------------
  logic wr_en, en_block, en_bypass;
  logic st_b, st_h;

  assign result      = is_div ? div_res : alu_res;
  assign exe_mem_bus = {gr_we, res_from_mem, dest, result, inst, pc};

  assign wr_en      = exe_valid_q & gr_we & (dest != 5'd0);
  assign en_block   = wr_en & (res_from_mem | (is_div & (state_q != DIV_DONE)));
  assign en_bypass  = wr_en & ~en_block;
  assign exe_wr_bus = {en_bypass, en_block, dest, result};

  assign st_b            = (inst[23:22] == 2'b00);
  assign st_h            = (inst[23:22] == 2'b01);
  assign data_sram_en    = exe_valid_q & (res_from_mem | mem_we);
  assign data_sram_addr  = alu_res;
  assign data_sram_we    = (exe_valid_q && mem_we) ?
                           (st_b ? (4'b0001 << alu_res[1:0]) :
                            st_h ? (4'b0011 << {alu_res[1], 1'b0}) : 4'b1111) : 4'b0000;
  assign data_sram_wdata = st_b ? {4{rkd_value[7:0]}} :
                           st_h ? {2{rkd_value[15:0]}} : rkd_value;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes {pc, result} expectations, a monitor pops them on each MEM handoff.
module tb_exe_stage;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         id_exe_valid = 1'b0;
  logic         mem_allowin = 1'b1;
  logic [186:0] id_exe_bus = '0;
  logic         exe_allowin, exe_mem_valid, data_sram_en;
  logic [102:0] exe_mem_bus;
  logic [38:0]  exe_wr_bus;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  logic [63:0] exp_q[$];

`ifdef EXE_DIV_RADIX4_EN
  localparam int unsigned BLK = 17;
`else
  localparam int unsigned BLK = 33;
`endif

  localparam logic [18:0] OP_ADD    = 19'h00001;
  localparam logic [18:0] OP_DIV_W  = 19'h08000;
  localparam logic [18:0] OP_MOD_W  = 19'h10000;
  localparam logic [18:0] OP_DIV_WU = 19'h20000;
  localparam logic [18:0] OP_MOD_WU = 19'h40000;

  exe_stage #(.DIV_BITS(32)) dut (
    .clk(clk), .resetn(resetn),
    .id_exe_valid(id_exe_valid), .exe_allowin(exe_allowin), .id_exe_bus(id_exe_bus),
    .mem_allowin(mem_allowin), .exe_mem_valid(exe_mem_valid), .exe_mem_bus(exe_mem_bus),
    .exe_wr_bus(exe_wr_bus), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [186:0] mk(input logic gw, input logic mw, input logic rfm,
                                      input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [4:0] dst, input logic [31:0] rkd, input logic [31:0] ins,
                                      input logic [31:0] p);
    return {gw, mw, rfm, op, s1, s2, dst, rkd, ins, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic issue(input logic [186:0] b, input logic [31:0] res);
    int unsigned n;
    logic ok;
    id_exe_valid = 1'b1;
    id_exe_bus   = b;
    exp_q.push_back({b[31:0], res});
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = exe_allowin;
      n++;
      @(posedge clk); #1;
    end
    id_exe_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL issue_accept: pc %0h not accepted after %0d cycles", b[31:0], n);
      void'(exp_q.pop_back());
    end
  endtask

  task automatic wait_div(input string name);
    int unsigned blk;
    blk = 0;
    @(negedge clk);
    while (exe_wr_bus[37] && blk < 100) begin
      blk++;
      @(negedge clk);
    end
    chk({name, "_block_cycles"}, 64'(blk), 64'(BLK));
    chk({name, "_out_valid"}, 64'(exe_mem_valid), 64'd1);
  endtask

  task automatic div_op(input string name, input logic [18:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [31:0] p);
    issue(mk(1'b1, 1'b0, 1'b0, op, a, b, 5'd4, 32'd0, 32'd0, p), res);
    wait_div(name);
    @(posedge clk); #1;
  endtask

  // Monitor: every MEM handoff must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (resetn && exe_mem_valid && mem_allowin) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected: output pc %0h result %0h with no expectation",
                 exe_mem_bus[31:0], exe_mem_bus[95:64]);
      end else begin
        chk("sb_pc_result", {exe_mem_bus[31:0], exe_mem_bus[95:64]}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int unsigned n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 64'(exe_mem_valid), 64'd0);
    chk("rst_allowin", 64'(exe_allowin), 64'd1);
    chk("rst_sram_en", 64'(data_sram_en), 64'd0);
    chk("rst_wr_en_bits", 64'(exe_wr_bus[38:37]), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    issue(mk(1'b1, 1'b0, 1'b0, OP_ADD, 32'd5, 32'd7, 5'd3, 32'd0, 32'd0, 32'h100), 32'd12);
    @(negedge clk);
    chk("add_valid", 64'(exe_mem_valid), 64'd1);
    chk("add_bypass", 64'(exe_wr_bus[38]), 64'd1);
    chk("add_block", 64'(exe_wr_bus[37]), 64'd0);
    chk("add_wdata", 64'(exe_wr_bus[31:0]), 64'd12);
    @(posedge clk); #1;

    div_op("div_w_neg", OP_DIV_W, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'h104);
    div_op("mod_w_neg", OP_MOD_W, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'h108);
    div_op("div_wu_z",  OP_DIV_WU, 32'd100, 32'd0, 32'hFFFFFFFF, 32'h10C);
    div_op("mod_wu_z",  OP_MOD_WU, 32'd100, 32'd0, 32'd100, 32'h110);
    div_op("div_w_ovf", OP_DIV_W, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h114);
    div_op("mod_w_ovf", OP_MOD_W, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h118);

    issue(mk(1'b0, 1'b1, 1'b0, OP_ADD, 32'h1000, 32'd3, 5'd0, 32'h000000AB, 32'h0000_0000, 32'h11C), 32'h1003);
    @(negedge clk);
    chk("stb_en", 64'(data_sram_en), 64'd1);
    chk("stb_we", 64'(data_sram_we), 64'b1000);
    chk("stb_addr", 64'(data_sram_addr), 64'h1003);
    chk("stb_wdata", 64'(data_sram_wdata), 64'hABABABAB);
    @(posedge clk); #1;

    issue(mk(1'b0, 1'b1, 1'b0, OP_ADD, 32'h1000, 32'd2, 5'd0, 32'h1234CDEF, 32'h0040_0000, 32'h120), 32'h1002);
    @(negedge clk);
    chk("sth_we", 64'(data_sram_we), 64'b1100);
    chk("sth_wdata", 64'(data_sram_wdata), 64'hCDEFCDEF);
    @(posedge clk); #1;

    issue(mk(1'b1, 1'b0, 1'b1, OP_ADD, 32'h2000, 32'd8, 5'd5, 32'd0, 32'h0080_0000, 32'h124), 32'h2008);
    @(negedge clk);
    chk("ldw_block", 64'(exe_wr_bus[37]), 64'd1);
    chk("ldw_bypass", 64'(exe_wr_bus[38]), 64'd0);
    chk("ldw_we", 64'(data_sram_we), 64'd0);
    chk("ldw_en", 64'(data_sram_en), 64'd1);
    @(posedge clk); #1;

    mem_allowin = 1'b0;
    issue(mk(1'b1, 1'b0, 1'b0, OP_DIV_WU, 32'd100, 32'd7, 5'd4, 32'd0, 32'd0, 32'h128), 32'd14);
    wait_div("stall_div");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wdata", 64'(exe_wr_bus[31:0]), 64'd14);
      chk("stall_allowin", 64'(exe_allowin), 64'd0);
      chk("stall_valid", 64'(exe_mem_valid), 64'd1);
    end
    @(posedge clk); #1;
    mem_allowin = 1'b1;
    issue(mk(1'b1, 1'b0, 1'b0, OP_ADD, 32'd1, 32'd1, 5'd6, 32'd0, 32'd0, 32'h12C), 32'd2);
    @(negedge clk);
    chk("post_stall_valid", 64'(exe_mem_valid), 64'd1);
    chk("post_stall_wdata", 64'(exe_wr_bus[31:0]), 64'd2);
    @(posedge clk); #1;

    issue(mk(1'b1, 1'b0, 1'b0, OP_DIV_W, 32'd1000, 32'd3, 5'd4, 32'd0, 32'd0, 32'h130), 32'd333);
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(exe_mem_valid), 64'd0);
    chk("midrst_block", 64'(exe_wr_bus[37]), 64'd0);
    chk("midrst_allowin", 64'(exe_allowin), 64'd1);
    @(posedge clk); #1;
    div_op("post_rst_divwu", OP_DIV_WU, 32'd9, 32'd3, 32'd3, 32'h134);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
